pc_next_gen: RTL and testbench
==============================

// Module: pc_next_gen
// PURPOSE
//  Next-generation fetch-PC generator. It owns the architectural fetch PC register and arbitrates all redirect sources.
//  Redirect sources: exception, ERET, branch/JR, immediate jump.
//  Handles MIPS delay-slot ordering by deferring branch targets until the delay slot is issued.
//  Sits between the EXE/CP0 redirect logic and the IF stage; exposes the PC with a valid/ready fetch handshake.
// PARAMETERS
//  PC_W        32            PC width in bits
//  FETCH_W     1             instructions per fetch group (power of 2: 1,2,4); sequential step = 4*FETCH_W bytes
//  RESET_PC    32'hBFC0_0000 PC loaded by reset
//  DELAY_SLOT  1             1: honour br_ds_pending; 0: branch redirects always immediate
// PORTS
//  clk            in   1     clock
//  rst            in   1     synchronous active-high reset
//  fetch_ready    in   1     IF accepts pc this cycle
//  exc_valid      in   1     exception redirect request
//  exc_target     in   PC_W  exception vector
//  eret_valid     in   1     ERET redirect request
//  epc            in   PC_W  ERET target
//  br_valid       in   1     taken branch/JR redirect
//  br_target      in   PC_W  branch/JR target
//  br_ds_pending  in   1     delay slot of this branch not yet issued (qualified by br_valid)
//  jmp_valid      in   1     J/JAL redirect from ID
//  jmp_target     in   PC_W  jump target
//  pc             out  PC_W  current fetch address
//  pc_valid       out  1     pc holds a fetchable address
//  pc_sel         out  3     source of last pc load: 000 seq, 001 jmp, 010 eret, 011 exc, 100 br
//  redirect       out  1     1-cycle pulse: pc was just loaded from a non-sequential source
// BEHAVIOUR
//  Reset: pc=RESET_PC, pc_valid=0, pc_sel=000, redirect=0, state=SEQ, pend_target=0.
//  pc_valid rises on the first cycle after rst deasserts and then stays 1.
//  Handshake:
//   - A PC is accepted when pc_valid & fetch_ready.
//   - On acceptance with no redirect, the next cycle's pc is the sequential value.
//   - Sequential value: {pc[PC_W-1:G], G'b0} + 4*FETCH_W, where G = log2(4*FETCH_W). The add wraps modulo 2^PC_W.
//   - Without acceptance, pc holds its value.
//  Priority, per cycle: exc > eret > br > jmp > sequential.
//   - Only the winning source is used; all lower-priority requests that cycle are dropped.
//  Immediate redirect:
//   - Exc, eret, jmp, and br with (br_ds_pending=0 or DELAY_SLOT=0) load pc <= target next cycle.
//   - This happens regardless of fetch_ready; the unaccepted pc is squashed.
//   - The same cycle sets redirect=1 and pc_sel=code.
//  Target bits are passed unmodified; misalignment is flagged downstream.
//  State machine (DELAY_SLOT=1):
//   - SEQ: br_valid & br_ds_pending & no exc/eret:
//     - If the current pc is accepted this cycle, it is the delay slot: pc <= br_target next cycle, stay SEQ.
//     - Otherwise pend_target <= br_target, go PEND_DS; pc holds (it is the delay slot).
//   - PEND_DS, on acceptance: pc <= pend_target, redirect=1, pc_sel=100, go SEQ.
//   - PEND_DS + exc/eret: that redirect wins, pend_target is discarded, go SEQ.
//   - PEND_DS: br_valid/jmp_valid are ignored (branch in a delay slot is architecturally undefined).
//  pc_sel is updated only on a pc load. A sequential load sets 000. It holds during stalls.
//  redirect is 0 on all cycles except the cycle immediately after a non-sequential load decision.
//  rst asserted mid-operation (incl. PEND_DS) restores all reset values on the next edge.
// TESTING
//  1. rst 2 cycles, fetch_ready=1 -> pc=BFC00000 with pc_valid=1 first post-reset cycle; then BFC00004, BFC00008.
//  2. FETCH_W=2, pc=BFC00004 accepted -> next pc=BFC00008; pc=FFFFFFF8 accepted -> pc=00000000 (wrap).
//  3. fetch_ready=0 for 3 cycles -> pc, pc_sel stable; exc_valid, exc_target=BFC00380, br_valid same cycle -> pc=BFC00380, pc_sel=011, redirect pulse 1 cycle.
//  4. pc=80000010 with fetch_ready=0, br_valid+br_ds_pending, br_target=80000100 -> pc stays 80000010 (PEND_DS) until fetch_ready=1 -> next pc=80000100, pc_sel=100.
//  5. In PEND_DS (target 80000100), eret_valid, epc=80000040 -> pc=80000040, pc_sel=010; after 80000040 is accepted, next pc=80000044 (pending discarded).
//  6. jmp_valid+br_valid (ds_pending=0) same cycle -> br_target wins; DELAY_SLOT=0 with ds_pending=1 -> immediate redirect.

Source files
------------

// File: rtl/pc_next_gen.sv
// Fetch-PC generator: owns the architectural fetch PC and arbitrates
// exception, ERET, branch/JR and jump redirects, deferring delay-slot branches.
module pc_next_gen #(
  parameter int              PC_W       = 32,
  parameter int              FETCH_W    = 1,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(32'hBFC0_0000),
  parameter bit              DELAY_SLOT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_ready,
  input  logic            exc_valid,
  input  logic [PC_W-1:0] exc_target,
  input  logic            eret_valid,
  input  logic [PC_W-1:0] epc,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  input  logic            br_ds_pending,
  input  logic            jmp_valid,
  input  logic [PC_W-1:0] jmp_target,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic [2:0]      pc_sel,
  output logic            redirect
);

  localparam int              G          = 2 + $clog2(FETCH_W);
  localparam logic [PC_W-1:0] STEP       = PC_W'(4 * FETCH_W);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'((64'd1 << G) - 64'd1));

  localparam logic [2:0] SEL_SEQ  = 3'b000;
  localparam logic [2:0] SEL_JMP  = 3'b001;
  localparam logic [2:0] SEL_ERET = 3'b010;
  localparam logic [2:0] SEL_EXC  = 3'b011;
  localparam logic [2:0] SEL_BR   = 3'b100;

  typedef enum logic [0:0] {
    ST_SEQ     = 1'b0,
    ST_PEND_DS = 1'b1
  } state_t;

  state_t          state_r;
  logic [PC_W-1:0] pend_target_r;

  logic            accept_s;
  logic            br_defer_s;
  logic [PC_W-1:0] seq_pc_s;
  logic [PC_W-1:0] next_pc_s;
  logic [2:0]      next_sel_s;
  logic            next_redirect_s;
  state_t          next_state_s;
  logic [PC_W-1:0] next_pend_s;

  assign accept_s   = pc_valid & fetch_ready;
  assign br_defer_s = br_valid & br_ds_pending & DELAY_SLOT;
  assign seq_pc_s   = (pc & ALIGN_MASK) + STEP;

  // Redirect arbitration and delay-slot state machine: next-cycle values.
  always_comb begin
    next_pc_s       = pc;
    next_sel_s      = pc_sel;
    next_redirect_s = 1'b0;
    next_state_s    = state_r;
    next_pend_s     = pend_target_r;
    case (state_r)
      ST_SEQ: begin
        if (exc_valid) begin
          next_pc_s       = exc_target;
          next_sel_s      = SEL_EXC;
          next_redirect_s = 1'b1;
        end else if (eret_valid) begin
          next_pc_s       = epc;
          next_sel_s      = SEL_ERET;
          next_redirect_s = 1'b1;
        end else if (br_valid) begin
          if (br_defer_s && !accept_s) begin
            // The held pc is the delay slot; remember the target until it issues.
            next_pend_s  = br_target;
            next_state_s = ST_PEND_DS;
          end else begin
            next_pc_s       = br_target;
            next_sel_s      = SEL_BR;
            next_redirect_s = 1'b1;
          end
        end else if (jmp_valid) begin
          next_pc_s       = jmp_target;
          next_sel_s      = SEL_JMP;
          next_redirect_s = 1'b1;
        end else if (accept_s) begin
          next_pc_s  = seq_pc_s;
          next_sel_s = SEL_SEQ;
        end else begin
          next_pc_s = pc;
        end
      end
      ST_PEND_DS: begin
        if (exc_valid) begin
          next_pc_s       = exc_target;
          next_sel_s      = SEL_EXC;
          next_redirect_s = 1'b1;
          next_state_s    = ST_SEQ;
        end else if (eret_valid) begin
          next_pc_s       = epc;
          next_sel_s      = SEL_ERET;
          next_redirect_s = 1'b1;
          next_state_s    = ST_SEQ;
        end else if (accept_s) begin
          next_pc_s       = pend_target_r;
          next_sel_s      = SEL_BR;
          next_redirect_s = 1'b1;
          next_state_s    = ST_SEQ;
        end else begin
          next_state_s = ST_PEND_DS;
        end
      end
      default: begin
        next_state_s = ST_SEQ;
      end
    endcase
  end

  // Architectural PC, handshake and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      pc_valid      <= 1'b0;
      pc_sel        <= SEL_SEQ;
      redirect      <= 1'b0;
      state_r       <= ST_SEQ;
      pend_target_r <= '0;
    end else begin
      pc            <= next_pc_s;
      pc_valid      <= 1'b1;
      pc_sel        <= next_sel_s;
      redirect      <= next_redirect_s;
      state_r       <= next_state_s;
      pend_target_r <= next_pend_s;
    end
  end

endmodule

// File: tb/tb_pc_next_gen.sv
// Directed bench for pc_next_gen: default instance plus a FETCH_W=2, DELAY_SLOT=0 instance.
module tb_pc_next_gen;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          failures = 0;

  logic        fetch_ready, exc_valid, eret_valid, br_valid, br_ds_pending, jmp_valid;
  logic [31:0] exc_target, epc, br_target, jmp_target;
  logic [31:0] pc;
  logic        pc_valid, redirect;
  logic [2:0]  pc_sel;

  logic        b_ready, b_br_valid, b_ds, b_jmp_valid;
  logic [31:0] b_br_target, b_jmp_target;
  logic [31:0] b_pc;
  logic        b_pc_valid, b_redirect;
  logic [2:0]  b_pc_sel;

  always #5 clk = ~clk;

  pc_next_gen dut_a (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready),
    .exc_valid(exc_valid), .exc_target(exc_target),
    .eret_valid(eret_valid), .epc(epc),
    .br_valid(br_valid), .br_target(br_target), .br_ds_pending(br_ds_pending),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .pc(pc), .pc_valid(pc_valid), .pc_sel(pc_sel), .redirect(redirect)
  );

  pc_next_gen #(.FETCH_W(2), .DELAY_SLOT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .fetch_ready(b_ready),
    .exc_valid(1'b0), .exc_target(32'h0000_0000),
    .eret_valid(1'b0), .epc(32'h0000_0000),
    .br_valid(b_br_valid), .br_target(b_br_target), .br_ds_pending(b_ds),
    .jmp_valid(b_jmp_valid), .jmp_target(b_jmp_target),
    .pc(b_pc), .pc_valid(b_pc_valid), .pc_sel(b_pc_sel), .redirect(b_redirect)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    exc_valid = 1'b0; eret_valid = 1'b0; br_valid = 1'b0;
    br_ds_pending = 1'b0; jmp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch_ready = 1'b1; clear_req();
    exc_target = 32'h0; epc = 32'h0; br_target = 32'h0; jmp_target = 32'h0;
    b_ready = 1'b0; b_br_valid = 1'b0; b_ds = 1'b0; b_jmp_valid = 1'b0;
    b_br_target = 32'h0; b_jmp_target = 32'h0;

    // 1. reset and sequential fetch
    step(); step();
    check("rst_pc", pc, 32'hBFC0_0000);
    check("rst_valid", {31'd0, pc_valid}, 32'd0);
    check("rst_sel", {29'd0, pc_sel}, 32'd0);
    check("rst_redirect", {31'd0, redirect}, 32'd0);
    rst = 1'b0;
    step();
    check("first_valid", {31'd0, pc_valid}, 32'd1);
    check("first_pc", pc, 32'hBFC0_0000);
    step();
    check("seq1", pc, 32'hBFC0_0004);
    step();
    check("seq2", pc, 32'hBFC0_0008);
    check("seq_sel", {29'd0, pc_sel}, 32'd0);

    // 3. stall, then exc beats eret and br in the same cycle
    fetch_ready = 1'b0;
    step(); step(); step();
    check("stall_pc", pc, 32'hBFC0_0008);
    check("stall_sel", {29'd0, pc_sel}, 32'd0);
    exc_valid = 1'b1; exc_target = 32'hBFC0_0380;
    eret_valid = 1'b1; epc = 32'h8000_0040;
    br_valid = 1'b1; br_target = 32'h1234_5678;
    step();
    clear_req();
    check("exc_pc", pc, 32'hBFC0_0380);
    check("exc_sel", {29'd0, pc_sel}, 32'd3);
    check("exc_redirect", {31'd0, redirect}, 32'd1);
    step();
    check("exc_redirect_drop", {31'd0, redirect}, 32'd0);
    check("exc_hold", pc, 32'hBFC0_0380);

    // 4. deferred delay-slot branch; jmp ignored while pending
    jmp_valid = 1'b1; jmp_target = 32'h8000_0010;
    step();
    clear_req();
    check("jmp_pc", pc, 32'h8000_0010);
    check("jmp_sel", {29'd0, pc_sel}, 32'd1);
    br_valid = 1'b1; br_ds_pending = 1'b1; br_target = 32'h8000_0100;
    step();
    clear_req();
    check("pend_pc", pc, 32'h8000_0010);
    check("pend_redirect", {31'd0, redirect}, 32'd0);
    check("pend_sel", {29'd0, pc_sel}, 32'd1);
    jmp_valid = 1'b1; jmp_target = 32'h9000_0000;
    step();
    clear_req();
    check("pend_jmp_ignored", pc, 32'h8000_0010);
    fetch_ready = 1'b1;
    step();
    check("pend_release_pc", pc, 32'h8000_0100);
    check("pend_release_sel", {29'd0, pc_sel}, 32'd4);
    check("pend_release_redirect", {31'd0, redirect}, 32'd1);

    // 5. eret during PEND_DS discards the pending target
    fetch_ready = 1'b0;
    br_valid = 1'b1; br_ds_pending = 1'b1; br_target = 32'h8000_0100;
    step();
    clear_req();
    eret_valid = 1'b1; epc = 32'h8000_0040;
    step();
    clear_req();
    check("eret_pc", pc, 32'h8000_0040);
    check("eret_sel", {29'd0, pc_sel}, 32'd2);
    fetch_ready = 1'b1;
    step();
    check("eret_seq", pc, 32'h8000_0044);
    check("eret_seq_sel", {29'd0, pc_sel}, 32'd0);
    check("eret_seq_redirect", {31'd0, redirect}, 32'd0);

    // delay-slot branch whose slot is accepted in the same cycle
    br_valid = 1'b1; br_ds_pending = 1'b1; br_target = 32'h8000_0200;
    step();
    clear_req();
    check("ds_accept_pc", pc, 32'h8000_0200);
    check("ds_accept_sel", {29'd0, pc_sel}, 32'd4);

    // 6. br beats jmp
    jmp_valid = 1'b1; jmp_target = 32'h8000_0300;
    br_valid = 1'b1; br_target = 32'h8000_0400;
    step();
    clear_req();
    check("br_over_jmp", pc, 32'h8000_0400);
    check("br_over_jmp_sel", {29'd0, pc_sel}, 32'd4);

    // reset while in PEND_DS
    fetch_ready = 1'b0;
    br_valid = 1'b1; br_ds_pending = 1'b1; br_target = 32'h8000_0500;
    step();
    clear_req();
    rst = 1'b1;
    step();
    check("midrst_pc", pc, 32'hBFC0_0000);
    check("midrst_valid", {31'd0, pc_valid}, 32'd0);
    check("midrst_sel", {29'd0, pc_sel}, 32'd0);
    rst = 1'b0; fetch_ready = 1'b1;
    step();
    check("midrst_first", pc, 32'hBFC0_0000);
    step();
    check("midrst_seq", pc, 32'hBFC0_0004);

    // 2. FETCH_W=2 step and wrap
    b_jmp_valid = 1'b1; b_jmp_target = 32'hBFC0_0004;
    step();
    b_jmp_valid = 1'b0; b_ready = 1'b1;
    check("b_jmp_pc", b_pc, 32'hBFC0_0004);
    step();
    check("b_seq1", b_pc, 32'hBFC0_0008);
    step();
    check("b_seq2", b_pc, 32'hBFC0_0010);
    b_ready = 1'b0; b_jmp_valid = 1'b1; b_jmp_target = 32'hFFFF_FFF8;
    step();
    b_jmp_valid = 1'b0; b_ready = 1'b1;
    step();
    check("b_wrap", b_pc, 32'h0000_0000);

    // 6. DELAY_SLOT=0: ds_pending ignored, redirect immediate
    b_ready = 1'b0; b_br_valid = 1'b1; b_ds = 1'b1; b_br_target = 32'h8000_0100;
    step();
    b_br_valid = 1'b0; b_ds = 1'b0;
    check("b_nods_pc", b_pc, 32'h8000_0100);
    check("b_nods_sel", {29'd0, b_pc_sel}, 32'd4);
    check("b_nods_redirect", {31'd0, b_redirect}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
